spi_master_ctrl: RTL and testbench

- Single-word SPI master controller that sequences the spi bus (sck, mosi, miso) plus an active-low chip select.
- Accepts a DATA_WIDTH word on a valid/ready request port, generates sck by dividing clk, and shifts the word out MSB-first on mosi while capturing miso.
- Returns the received word on a one-cycle rx pulse.
- Serves as the DUT-side master that spi_if initiator/responder agents exercise.

---
 rtl/spi_ctrl_pkg.sv | 33 +++
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_clk_gen.sv | 44 ++++
 rtl/spi_master_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI master controller: FSM state encoding and SPI mode constants.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

    // Map raw CPOL/CPHA parameter bits onto one of the four named modes.
    function automatic spi_mode_t mode_of(input logic cpol, input logic cpha);
        spi_mode_t m;
        case ({cpol, cpha})
            2'b00:   m = SPI_MODE0;
            2'b01:   m = SPI_MODE1;
            2'b10:   m = SPI_MODE2;
            default: m = SPI_MODE3;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Request/response handshake plus SPI pins of the SPI master controller.
interface spi_master_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  sck_o;
    logic                  cs_n_o;
    logic                  mosi_o;
    logic                  miso_i;

    modport master (
        input  tx_valid, tx_data, miso_i,
        output tx_ready, rx_valid, rx_data, busy, sck_o, cs_n_o, mosi_o
    );

    modport slave (
        output tx_valid, tx_data, miso_i,
        input  tx_ready, rx_valid, rx_data, busy, sck_o, cs_n_o, mosi_o
    );
endinterface

// File: rtl/spi_clk_gen.sv
// SCK generator: divides clk into half-periods and flags leading/trailing sck edges.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter bit          CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_park,
    output logic o_tick_c,
    output logic o_leading_c,
    output logic o_trailing_c,
    output logic o_sck
);
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sck;

    // Edge type is decided by the sck level the tick is about to leave.
    assign o_tick_c     = i_enable && (r_div_cnt == DIV_LAST);
    assign o_leading_c  = o_tick_c && !i_park && (r_sck == CPOL);
    assign o_trailing_c = o_tick_c && !i_park && (r_sck != CPOL);
    assign o_sck        = r_sck;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sck     <= CPOL;
        end else begin
            if (!i_enable || o_tick_c) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (i_park) begin
                r_sck <= CPOL;
            end else if (o_tick_c) begin
                r_sck <= ~r_sck;
            end
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: accepts a word, frames it with cs_n, shifts MSB-first, returns the received word.
module spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input logic               clk,
    input logic               rst,
    spi_master_ctrl_if.master bus
);
    localparam spi_mode_t         MODE      = mode_of(CPOL, CPHA);
    localparam int unsigned       EDGE_W    = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    spi_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [EDGE_W-1:0]     r_edge_cnt;
    logic                  r_cs_n;
    logic                  r_mosi;
    logic                  r_tx_ready;
    logic                  r_busy;
    logic                  r_rx_valid;

    logic w_enable;
    logic w_park;
    logic w_tick;
    logic w_leading;
    logic w_trailing;
    logic w_sck;
    logic w_last;

    assign w_enable = (r_state != IDLE);
    assign w_park   = (r_state != SHIFT);
    assign w_last   = (r_edge_cnt == EDGE_LAST);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (MODE.cpol)
    ) u_clk_gen (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (w_enable),
        .i_park       (w_park),
        .o_tick_c     (w_tick),
        .o_leading_c  (w_leading),
        .o_trailing_c (w_trailing),
        .o_sck        (w_sck)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_edge_cnt <= '0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        r_state    <= LEAD;
                        r_tx_shift <= bus.tx_data;
                        r_edge_cnt <= '0;
                        r_cs_n     <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (!MODE.cpha) begin
                            r_mosi <= bus.tx_data[DATA_WIDTH-1];
                        end
                    end
                end
                LEAD: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_leading) begin
                        if (!MODE.cpha) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], bus.miso_i};
                        end else begin
                            r_mosi     <= r_tx_shift[DATA_WIDTH-1];
                            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    // CPHA=0 keeps the last bit on mosi through the final trailing edge.
                    if (w_trailing) begin
                        if (!MODE.cpha) begin
                            if (!w_last) begin
                                r_mosi     <= r_tx_shift[DATA_WIDTH-2];
                                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], bus.miso_i};
                        end
                    end
                    if (w_tick) begin
                        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                        if (w_last) begin
                            r_state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (w_tick) begin
                        r_state    <= IDLE;
                        r_cs_n     <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.busy     = r_busy;
    assign bus.sck_o    = w_sck;
    assign bus.cs_n_o   = r_cs_n;
    assign bus.mosi_o   = r_mosi;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: mode 0 / mode 3 at CLK_DIV=2 and mode 0 at CLK_DIV=1.
module tb_spi_master_ctrl;
    import spi_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATA_WIDTH(8)) if0 ();
    spi_master_ctrl_if #(.DATA_WIDTH(8)) if3 ();
    spi_master_ctrl_if #(.DATA_WIDTH(8)) if1 ();

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(SPI_MODE0.cpol), .CPHA(SPI_MODE0.cpha))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(SPI_MODE3.cpol), .CPHA(SPI_MODE3.cpha))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1), .CPOL(SPI_MODE0.cpol), .CPHA(SPI_MODE0.cpha))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Slave models: mode 0 changes data on falling sck, mode 3 drives data on falling (leading) sck.
    logic       loop0;
    logic [7:0] resp0, resp3;
    int         k0, k3;
    logic [7:0] sh0;
    logic [8:0] sh3;

    always @(negedge if0.sck_o or posedge if0.cs_n_o)
        if (if0.cs_n_o !== 1'b0) k0 <= 0; else k0 <= k0 + 1;
    always @(negedge if3.sck_o or posedge if3.cs_n_o)
        if (if3.cs_n_o !== 1'b0) k3 <= 0; else k3 <= k3 + 1;

    assign sh0 = resp0 << k0;
    assign sh3 = {1'b0, resp3} << k3;
    assign if0.miso_i = loop0 ? if0.mosi_o : sh0[7];
    assign if3.miso_i = sh3[8];
    assign if1.miso_i = if1.mosi_o;

    int         sel;
    logic       obs_sck, obs_cs_n, obs_mosi, obs_rx_valid, obs_tx_ready, obs_busy;
    logic [7:0] obs_rx_data;

    always_comb begin
        obs_sck = if0.sck_o; obs_cs_n = if0.cs_n_o; obs_mosi = if0.mosi_o;
        obs_rx_valid = if0.rx_valid; obs_rx_data = if0.rx_data;
        obs_tx_ready = if0.tx_ready; obs_busy = if0.busy;
        if (sel == 3) begin
            obs_sck = if3.sck_o; obs_cs_n = if3.cs_n_o; obs_mosi = if3.mosi_o;
            obs_rx_valid = if3.rx_valid; obs_rx_data = if3.rx_data;
            obs_tx_ready = if3.tx_ready; obs_busy = if3.busy;
        end else if (sel == 1) begin
            obs_sck = if1.sck_o; obs_cs_n = if1.cs_n_o; obs_mosi = if1.mosi_o;
            obs_rx_valid = if1.rx_valid; obs_rx_data = if1.rx_data;
            obs_tx_ready = if1.tx_ready; obs_busy = if1.busy;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cs_low, rises, toggles, mosi_hi, mosi_off, rxv_cnt, rxv_at;
    logic [7:0] rxd;
    int t1, t2, cs_hi, rx_cnt;
    logic [7:0] d1, d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            0:       begin if0.tx_valid = v; if0.tx_data = d; end
            3:       begin if3.tx_valid = v; if3.tx_data = d; end
            default: begin if1.tx_valid = v; if1.tx_data = d; end
        endcase
    endtask

    // One request on the selected DUT, then 50 observed cycles of the resulting frame.
    task automatic xfer(input int s, input logic [7:0] d);
        logic p_sck, p_mosi;
        @(posedge clk); #1;
        drive(s, 1'b1, d);
        @(posedge clk); #1;
        drive(s, 1'b0, 8'h00);
        cs_low = 0; rises = 0; toggles = 0; mosi_hi = 0; mosi_off = 0;
        rxv_cnt = 0; rxv_at = -1; rxd = 8'h00;
        p_sck = obs_sck; p_mosi = obs_mosi;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!obs_cs_n) cs_low++;
            if (obs_sck != p_sck) toggles++;
            if (obs_sck && !p_sck) rises++;
            if (obs_mosi) mosi_hi++;
            if (!obs_cs_n && (obs_mosi != p_mosi) && !(p_sck && !obs_sck)) mosi_off++;
            if (obs_rx_valid) begin
                rxv_cnt++;
                if (rxv_at < 0) begin rxv_at = c; rxd = obs_rx_data; end
            end
            p_sck = obs_sck; p_mosi = obs_mosi;
        end
    endtask

    initial begin
        rst = 1'b1; sel = 0; loop0 = 1'b1; resp0 = 8'h00; resp3 = 8'h00;
        drive(0, 1'b0, 8'h00); drive(3, 1'b0, 8'h00); drive(1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", if0.cs_n_o, 1'b1);
        chk("rst_sck0", if0.sck_o, 1'b0);
        chk("rst_mosi", if0.mosi_o, 1'b0);
        chk("rst_tx_ready", if0.tx_ready, 1'b1);
        chk("rst_busy", if0.busy, 1'b0);
        chk("rst_rx_valid", if0.rx_valid, 1'b0);
        chk("rst_rx_data", if0.rx_data, 8'h00);
        chk("rst_sck3", if3.sck_o, 1'b1);
        chk("rst_ready1", if1.tx_ready, 1'b1);

        // Mode 0 loopback
        sel = 0; loop0 = 1'b1;
        xfer(0, 8'hA5);
        chk("m0_cs_low", cs_low, 36);
        chk("m0_rises", rises, 8);
        chk("m0_rxv_cnt", rxv_cnt, 1);
        chk("m0_rxv_at", rxv_at, 36);
        chk("m0_rx_data", rxd, 8'hA5);
        chk("m0_mosi_edges", mosi_off, 0);
        chk("m0_rx_held", obs_rx_data, 8'hA5);
        chk("m0_idle_busy", obs_busy, 1'b0);

        // Mode 0 against a slave returning 0x3C
        loop0 = 1'b0; resp0 = 8'h3C;
        xfer(0, 8'h00);
        chk("m0s_mosi_zero", mosi_hi, 0);
        chk("m0s_rx_data", rxd, 8'h3C);
        chk("m0s_rxv_cnt", rxv_cnt, 1);

        // Mode 3 against a slave returning 0x7E
        sel = 3; resp3 = 8'h7E;
        @(negedge clk);
        chk("m3_sck_idle", obs_sck, 1'b1);
        xfer(3, 8'h81);
        chk("m3_cs_low", cs_low, 36);
        chk("m3_rises", rises, 8);
        chk("m3_mosi_edges", mosi_off, 0);
        chk("m3_rx_data", rxd, 8'h7E);
        chk("m3_rxv_at", rxv_at, 36);
        chk("m3_sck_park", obs_sck, 1'b1);

        // Back-to-back with tx_valid held across two words
        sel = 0; loop0 = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 8'h11);
        @(posedge clk); #1;
        drive(0, 1'b1, 8'h22);
        rx_cnt = 0; t1 = -1; t2 = -1; cs_hi = 0; d1 = 8'h00; d2 = 8'h00;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (obs_rx_valid) begin
                rx_cnt++;
                if (rx_cnt == 1) begin t1 = c; d1 = obs_rx_data; end
                else begin t2 = c; d2 = obs_rx_data; end
            end
            if (obs_cs_n && rx_cnt < 2) cs_hi++;
            if (rx_cnt == 1 && obs_rx_valid) begin
                @(posedge clk); #1;
                drive(0, 1'b0, 8'h00);
            end
        end
        chk("b2b_rx_cnt", rx_cnt, 2);
        chk("b2b_t1", t1, 36);
        chk("b2b_gap", t2 - t1, 37);
        chk("b2b_cs_hi", cs_hi, 1);
        chk("b2b_d1", d1, 8'h11);
        chk("b2b_d2", d2, 8'h22);

        // Reset in the middle of SHIFT
        @(posedge clk); #1;
        drive(0, 1'b1, 8'hC3);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00);
        repeat (12) @(negedge clk);
        chk("mid_busy", obs_busy, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_cs_n", obs_cs_n, 1'b1);
        chk("mrst_sck", obs_sck, 1'b0);
        chk("mrst_tx_ready", obs_tx_ready, 1'b1);
        chk("mrst_busy", obs_busy, 1'b0);
        chk("mrst_mosi", obs_mosi, 1'b0);
        rxv_cnt = 0; cs_low = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (obs_rx_valid) rxv_cnt++;
            if (!obs_cs_n) cs_low++;
        end
        chk("mrst_no_rxv", rxv_cnt, 0);
        chk("mrst_no_cs", cs_low, 0);
        xfer(0, 8'hF0);
        chk("post_rst_rx", rxd, 8'hF0);
        chk("post_rst_cs", cs_low, 36);
        chk("post_rst_rxv", rxv_cnt, 1);

        // CLK_DIV=1 loopback
        sel = 1;
        xfer(1, 8'h5A);
        chk("d1_cs_low", cs_low, 18);
        chk("d1_toggles", toggles, 16);
        chk("d1_rxv_at", rxv_at, 18);
        chk("d1_rx_data", rxd, 8'h5A);
        chk("d1_rxv_cnt", rxv_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
